// File: rtl/reflet_dma_pkg.sv
// Shared definitions for the reflet DMA controller: register map, CTRL/STATUS
// bit positions and the channel FSM encoding.
package reflet_dma_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned NUM_CFG  = 6;

  localparam logic [2:0] OFF_SRC_L  = 3'd0;
  localparam logic [2:0] OFF_SRC_H  = 3'd1;
  localparam logic [2:0] OFF_DST_L  = 3'd2;
  localparam logic [2:0] OFF_DST_H  = 3'd3;
  localparam logic [2:0] OFF_LEN_L  = 3'd4;
  localparam logic [2:0] OFF_LEN_H  = 3'd5;
  localparam logic [2:0] OFF_CTRL   = 3'd6;
  localparam logic [2:0] OFF_STATUS = 3'd7;

  localparam int unsigned CTRL_START     = 0;
  localparam int unsigned CTRL_IRQ_EN    = 1;
  localparam int unsigned CTRL_SRC_FIXED = 2;
  localparam int unsigned CTRL_DST_FIXED = 3;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } dma_state_e;

endpackage

// File: rtl/reflet_dma_regs.sv
// Slave-side register block: address decode, CTRL/STATUS storage and the
// registered read mux. Address/length counters live in the top.
module reflet_dma_regs
  import reflet_dma_pkg::*;
#(
  parameter int unsigned base_addr_size = 15,
  parameter int unsigned base_addr      = 32'h7F10
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic [base_addr_size-1:0] addr_i,
  input  logic [3:0]                wdata_i,
  input  logic                      write_en_i,
  input  logic                      busy_i,
  input  logic                      done_set_i,
  input  logic [WORD_W-1:0]         src_i,
  input  logic [WORD_W-1:0]         dst_i,
  input  logic [WORD_W-1:0]         len_i,
  input  logic [BYTE_W-1:0]         rdata_lo_i,
  output logic [BYTE_W-1:0]         data_out_o,
  output logic [NUM_CFG-1:0]        cfg_we_c_o,
  output logic                      start_c_o,
  output logic                      irq_en_o,
  output logic                      src_fixed_o,
  output logic                      dst_fixed_o
);

  logic [base_addr_size-1:0] off_c;
  logic [2:0]                idx_c;
  logic                      hit_c;
  logic                      wr_c;
  logic [BYTE_W-1:0]         rdata_c;
  logic [BYTE_W-1:0]         data_out_q;
  logic                      irq_en_q, src_fixed_q, dst_fixed_q, done_q;

  assign off_c = addr_i - base_addr_size'(base_addr);
  assign hit_c = enable_i && (off_c < base_addr_size'(NUM_REGS));
  assign idx_c = off_c[2:0];
  assign wr_c  = hit_c && write_en_i;

  assign start_c_o   = wr_c && !busy_i && (idx_c == OFF_CTRL) && wdata_i[CTRL_START];
  assign data_out_o  = data_out_q;
  assign irq_en_o    = irq_en_q;
  assign src_fixed_o = src_fixed_q;
  assign dst_fixed_o = dst_fixed_q;

  // Parameter bytes are frozen while a transfer is running.
  always_comb begin
    cfg_we_c_o = '0;
    if (wr_c && !busy_i && (idx_c <= OFF_LEN_H)) cfg_we_c_o[idx_c] = 1'b1;
  end

  always_comb begin
    rdata_c = '0;
    case (idx_c)
      OFF_SRC_L:  rdata_c = src_i[7:0];
      OFF_SRC_H:  rdata_c = src_i[15:8];
      OFF_DST_L:  rdata_c = dst_i[7:0];
      OFF_DST_H:  rdata_c = dst_i[15:8];
      OFF_LEN_L:  rdata_c = rdata_lo_i;
      OFF_LEN_H:  rdata_c = len_i[15:8];
      OFF_CTRL: begin
        rdata_c[CTRL_IRQ_EN]    = irq_en_q;
        rdata_c[CTRL_SRC_FIXED] = src_fixed_q;
        rdata_c[CTRL_DST_FIXED] = dst_fixed_q;
      end
      default: begin
        rdata_c[STAT_BUSY] = busy_i;
        rdata_c[STAT_DONE] = done_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_out_q  <= '0;
      irq_en_q    <= 1'b0;
      src_fixed_q <= 1'b0;
      dst_fixed_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      data_out_q <= hit_c ? rdata_c : '0;
      if (wr_c && !busy_i && (idx_c == OFF_CTRL)) begin
        irq_en_q    <= wdata_i[CTRL_IRQ_EN];
        src_fixed_q <= wdata_i[CTRL_SRC_FIXED];
        dst_fixed_q <= wdata_i[CTRL_DST_FIXED];
      end
      // Completion beats a simultaneous write-1-to-clear.
      if (done_set_i) done_q <= 1'b1;
      else if (wr_c && (idx_c == OFF_STATUS) && wdata_i[STAT_DONE]) done_q <= 1'b0;
    end
  end

endmodule

// File: rtl/reflet_dma.sv
// Single-channel word-copy DMA: CPU-programmed via the byte slave bus, moves
// LEN words from SRC to DST as a second system-bus master under bus_req/bus_gnt.
module reflet_dma
  import reflet_dma_pkg::*;
#(
  parameter int unsigned base_addr_size = 15,
  parameter int unsigned base_addr      = 32'h7F10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic [7:0]                data_in,
  input  logic                      write_en,
  output logic [7:0]                data_out,
  output logic                      bus_req,
  input  logic                      bus_gnt,
  output logic [15:0]               m_addr,
  input  logic [15:0]               m_data_in,
  output logic [15:0]               m_data_out,
  output logic                      m_write_en,
  output logic                      irq,
  output logic                      busy
);

  dma_state_e          state_q, state_d;
  logic [WORD_W-1:0]   src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [NUM_CFG-1:0]  cfg_we_c;
  logic                start_c, step_c;
  logic                irq_en, src_fixed, dst_fixed;
  logic                bus_req_q, bus_req_d, busy_q, busy_d, irq_q, irq_d;
  logic [WORD_W-1:0]   m_addr_q, m_addr_d;

  reflet_dma_regs #(
    .base_addr_size(base_addr_size),
    .base_addr     (base_addr)
  ) u_regs (
    .clk_i      (clk),
    .reset_i    (reset),
    .enable_i   (enable),
    .addr_i     (addr),
    .wdata_i    (data_in[3:0]),
    .write_en_i (write_en),
    .busy_i     (busy_q),
    .done_set_i (state_q == ST_DONE),
    .src_i      (src_q),
    .dst_i      (dst_q),
    .len_i      (len_q),
    .rdata_lo_i (len_q[7:0]),
    .data_out_o (data_out),
    .cfg_we_c_o (cfg_we_c),
    .start_c_o  (start_c),
    .irq_en_o   (irq_en),
    .src_fixed_o(src_fixed),
    .dst_fixed_o(dst_fixed)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Losing the grant in RD or WR restarts the current word from RD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_c) state_d = (len_q == '0) ? ST_DONE : ST_REQ;
      ST_REQ:  if (bus_gnt) state_d = ST_RD;
      ST_RD:   state_d = bus_gnt ? ST_WR : ST_REQ;
      ST_WR: begin
        if (!bus_gnt)                     state_d = ST_REQ;
        else if (len_q == WORD_W'(1))     state_d = ST_DONE;
        else                              state_d = ST_RD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req_d = 1'b0;
    busy_d    = 1'b0;
    irq_d     = 1'b0;
    m_addr_d  = m_addr_q;
    if (state_d inside {ST_REQ, ST_RD, ST_WR}) begin
      bus_req_d = 1'b1;
      busy_d    = 1'b1;
    end
    if (state_q == ST_DONE) irq_d = irq_en;
    if (state_d == ST_RD)      m_addr_d = src_d;
    else if (state_d == ST_WR) m_addr_d = dst_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req_q <= 1'b0;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
      m_addr_q  <= '0;
    end else begin
      bus_req_q <= bus_req_d;
      busy_q    <= busy_d;
      irq_q     <= irq_d;
      m_addr_q  <= m_addr_d;
    end
  end

  assign step_c = (state_q == ST_WR) && bus_gnt;

  // Counters: CPU byte loads when idle, post-write advance when running.
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    if (cfg_we_c[OFF_SRC_L]) src_d[7:0]  = data_in;
    if (cfg_we_c[OFF_SRC_H]) src_d[15:8] = data_in;
    if (cfg_we_c[OFF_DST_L]) dst_d[7:0]  = data_in;
    if (cfg_we_c[OFF_DST_H]) dst_d[15:8] = data_in;
    if (cfg_we_c[OFF_LEN_L]) len_d[7:0]  = data_in;
    if (cfg_we_c[OFF_LEN_H]) len_d[15:8] = data_in;
    if (step_c) begin
      if (!src_fixed) src_d = src_q + WORD_W'(1);
      if (!dst_fixed) dst_d = dst_q + WORD_W'(1);
      len_d = len_q - WORD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
    end
  end

  // Synchronous-RAM read data arrives during WR, so it is forwarded straight
  // to the write port; the strobe is qualified by the live grant.
  assign m_write_en = (state_q == ST_WR) && bus_gnt;
  assign m_data_out = m_write_en ? m_data_in : '0;
  assign bus_req    = bus_req_q;
  assign busy       = busy_q;
  assign irq        = irq_q;
  assign m_addr     = m_addr_q;

endmodule

// File: tb/tb_reflet_dma.sv
// Directed bench for reflet_dma: byte-register programming, a synchronous RAM
// on the master port, and hand-computed expectations.
module tb_reflet_dma;

  localparam logic [14:0] BASE = 15'h7F10;

  logic        clk = 1'b0;
  logic        reset, enable, write_en, bus_gnt;
  logic [14:0] addr;
  logic [7:0]  data_in, data_out;
  logic        bus_req, m_write_en, irq, busy;
  logic [15:0] m_addr, m_data_in, m_data_out;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0, irq_cnt = 0, viol_cnt = 0, req_cnt = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] rdata;

  reflet_dma dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .data_in(data_in),
    .write_en(write_en), .data_out(data_out), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_data_out(m_data_out),
    .m_write_en(m_write_en), .irq(irq), .busy(busy)
  );

  always #5 clk = ~clk;

  assign m_data_in = rdata;

  // Synchronous RAM seen through the arbiter: only honoured while granted.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h8100] = 16'h1234;
    mem[16'h8101] = 16'hBEEF;
    mem[16'h8102] = 16'h0F0F;
    mem[16'h8103] = 16'hC0DE;
    rdata = 16'h0000;
    forever begin
      @(posedge clk);
      if (bus_gnt) begin
        if (m_write_en) mem[m_addr] <= m_data_out;
        rdata <= mem[m_addr];
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (m_write_en) wr_cnt++;
    if (m_write_en && !bus_gnt) viol_cnt++;
    if (irq) irq_cnt++;
    if (bus_req) req_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input int unsigned off, input logic [7:0] d);
    @(negedge clk);
    enable = 1'b1; addr = BASE + 15'(off); data_in = d; write_en = 1'b1;
    @(negedge clk);
    enable = 1'b0; write_en = 1'b0; data_in = 8'h00;
  endtask

  task automatic reg_rd(input int unsigned off, output logic [7:0] d);
    @(negedge clk);
    enable = 1'b1; addr = BASE + 15'(off); write_en = 1'b0;
    @(negedge clk);
    d = data_out;
    enable = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    reg_wr(0, src[7:0]); reg_wr(1, src[15:8]);
    reg_wr(2, dst[7:0]); reg_wr(3, dst[15:8]);
    reg_wr(4, len[7:0]); reg_wr(5, len[15:8]);
  endtask

  // Called right after the start write; cyc counts posedges from the one that took it.
  task automatic wait_irq(output int cyc);
    cyc = 1;
    while (!irq && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [7:0] rd;
  int cyc, w0, i0, r0;

  initial begin
    reset = 1'b1; enable = 1'b0; addr = '0; data_in = '0; write_en = 1'b0; bus_gnt = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_m_we", 32'(m_write_en), 0);
    check("rst_m_addr", 32'(m_addr), 0);
    check("rst_data_out", 32'(data_out), 0);
    reg_rd(7, rd); check("rst_status", 32'(rd), 0);
    reg_rd(8, rd); check("miss_read", 32'(rd), 0);

    // Four-word copy with immediate grant.
    cfg(16'h8100, 16'h8200, 16'd4);
    w0 = wr_cnt; i0 = irq_cnt;
    reg_wr(6, 8'h03);
    wait_irq(cyc);
    check("t1_latency", 32'(cyc), 11);
    repeat (3) @(negedge clk);
    check("t1_writes", 32'(wr_cnt - w0), 4);
    check("t1_irq_pulses", 32'(irq_cnt - i0), 1);
    check("t1_m0", 32'(mem[16'h8200]), 32'h1234);
    check("t1_m1", 32'(mem[16'h8201]), 32'hBEEF);
    check("t1_m2", 32'(mem[16'h8202]), 32'h0F0F);
    check("t1_m3", 32'(mem[16'h8203]), 32'hC0DE);
    reg_rd(7, rd); check("t1_status", 32'(rd), 32'h02);
    reg_rd(0, rd); check("t1_src_l", 32'(rd), 32'h04);
    reg_rd(4, rd); check("t1_len_l", 32'(rd), 32'h00);
    reg_wr(7, 8'h02);
    reg_rd(7, rd); check("t1_done_clr", 32'(rd), 32'h00);

    // Zero length: completes without touching the bus.
    cfg(16'h8100, 16'h8200, 16'd0);
    w0 = wr_cnt; r0 = req_cnt;
    reg_wr(6, 8'h03);
    wait_irq(cyc);
    check("t2_latency", 32'(cyc), 2);
    repeat (2) @(negedge clk);
    check("t2_writes", 32'(wr_cnt - w0), 0);
    check("t2_bus_req", 32'(req_cnt - r0), 0);
    reg_rd(7, rd); check("t2_status", 32'(rd), 32'h02);
    reg_wr(7, 8'h02);

    // Grant withdrawn for 5 cycles in the middle of word 1.
    cfg(16'h8100, 16'h8400, 16'd3);
    w0 = wr_cnt;
    reg_wr(6, 8'h03);
    repeat (3) @(negedge clk);
    bus_gnt = 1'b0;
    w0 = w0 + 0;
    repeat (5) @(negedge clk);
    check("t3_req_held", 32'(bus_req), 1);
    check("t3_busy_held", 32'(busy), 1);
    check("t3_writes_stalled", 32'(wr_cnt - w0), 1);
    bus_gnt = 1'b1;
    wait_irq(cyc);
    check("t3_irq_seen", 32'(irq), 1);
    repeat (2) @(negedge clk);
    check("t3_writes", 32'(wr_cnt - w0), 3);
    check("t3_m0", 32'(mem[16'h8400]), 32'h1234);
    check("t3_m1", 32'(mem[16'h8401]), 32'hBEEF);
    check("t3_m2", 32'(mem[16'h8402]), 32'h0F0F);
    check("t3_m3_untouched", 32'(mem[16'h8403]), 32'h0000);
    check("t3_no_ungranted_we", 32'(viol_cnt), 0);
    reg_wr(7, 8'h02);

    // Fixed destination: every word lands on the same address.
    cfg(16'h8100, 16'h8500, 16'd3);
    w0 = wr_cnt;
    reg_wr(6, 8'h0B);
    wait_irq(cyc);
    check("t4_latency", 32'(cyc), 9);
    repeat (2) @(negedge clk);
    check("t4_writes", 32'(wr_cnt - w0), 3);
    check("t4_dst_val", 32'(mem[16'h8500]), 32'h0F0F);
    check("t4_dst_next", 32'(mem[16'h8501]), 32'h0000);
    reg_rd(0, rd); check("t4_src_l", 32'(rd), 32'h03);
    reg_rd(1, rd); check("t4_src_h", 32'(rd), 32'h81);
    reg_rd(2, rd); check("t4_dst_l", 32'(rd), 32'h00);
    reg_rd(6, rd); check("t4_ctrl", 32'(rd), 32'h0A);
    reg_wr(7, 8'h02);

    // Writes and a second start while busy are ignored.
    cfg(16'h8100, 16'h8600, 16'd4);
    w0 = wr_cnt; i0 = irq_cnt;
    reg_wr(6, 8'h03);
    reg_wr(0, 8'h55);
    reg_wr(6, 8'h03);
    reg_rd(7, rd); check("t5_status_busy", 32'(rd), 32'h01);
    cyc = 0;
    while (irq_cnt == i0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    repeat (12) @(negedge clk);
    check("t5_irq_pulses", 32'(irq_cnt - i0), 1);
    check("t5_writes", 32'(wr_cnt - w0), 4);
    check("t5_m0", 32'(mem[16'h8600]), 32'h1234);
    check("t5_m3", 32'(mem[16'h8603]), 32'hC0DE);
    reg_rd(0, rd); check("t5_src_l", 32'(rd), 32'h04);
    reg_wr(7, 8'h02);

    // Reset while the second word's write strobe is up.
    cfg(16'h8100, 16'h8700, 16'd4);
    i0 = irq_cnt;
    reg_wr(6, 8'h03);
    repeat (4) @(negedge clk);
    check("t6_pre_we", 32'(m_write_en), 1);
    reset = 1'b1;
    #1;
    check("t6_bus_req", 32'(bus_req), 0);
    check("t6_m_we", 32'(m_write_en), 0);
    check("t6_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    reg_rd(1, rd); check("t6_src_h", 32'(rd), 32'h00);
    reg_rd(4, rd); check("t6_len_l", 32'(rd), 32'h00);
    reg_rd(6, rd); check("t6_ctrl", 32'(rd), 32'h00);
    reg_rd(7, rd); check("t6_status", 32'(rd), 32'h00);
    repeat (10) @(negedge clk);
    check("t6_no_irq", 32'(irq_cnt - i0), 0);
    check("t6_m0", 32'(mem[16'h8700]), 32'h1234);
    check("t6_m1_untouched", 32'(mem[16'h8701]), 32'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
